key_schedule_engine: RTL and testbench



---
 rtl/key_schedule_engine_if.sv | 16 +
 rtl/key_schedule_engine.sv | 162 ++++++++++++++++
 tb/tb_key_schedule_engine.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/key_schedule_engine_if.sv
// Handshake and round-key read bus between the AES key-schedule engine and its user.
// Nk must match the engine it connects to.
interface key_schedule_engine_if #(
    parameter int Nk = 4
);
    logic              start;
    logic [32*Nk-1:0]  keyIn;
    logic              busy;
    logic              done;
    logic              ready;
    logic [3:0]        rdRound;
    logic [127:0]      rdKey;

    modport master (output start, keyIn, rdRound, input busy, done, ready, rdKey);
    modport slave  (input start, keyIn, rdRound, output busy, done, ready, rdKey);
endinterface

// File: rtl/key_schedule_engine.sv
// Iterative AES-128/192/256 key expansion: one schedule word per cycle into
// four word-lane memories, with a registered round-key read port.
module key_schedule_engine #(
    parameter int Nk = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    key_schedule_engine_if.slave bus
);
    localparam int Nr = Nk + 6;
    localparam int NumWords = 4 * (Nr + 1);
    localparam logic [5:0] LastIdx = 6'(NumWords - 1);
    localparam logic [5:0] NkIdx = 6'(Nk);
    localparam logic [2:0] NkLast = 3'(Nk - 1);
    localparam logic [3:0] NrIdx = 4'(Nr);

    generate
        if (Nk != 4 && Nk != 6 && Nk != 8) begin : gBadNk
            $error("key_schedule_engine: Nk must be 4, 6 or 8");
        end
    endgenerate

    localparam logic [0:255][7:0] SubTable = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, EXPAND} state_t;
    state_t stateReg, stateNext;

    logic        loadKey, writeWord, lastWord;
    logic [5:0]  idxReg;
    logic [2:0]  subIdxReg;
    logic [7:0]  rconReg;
    logic        doneReg, readyReg;
    logic [31:0] window [0:Nk-1];
    logic [31:0] temp, sboxIn, sboxOut, mixed, newWord;
    logic        rdOk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stateReg <= IDLE;
        else       stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        loadKey   = 1'b0;
        writeWord = 1'b0;
        lastWord  = 1'b0;
        case (stateReg)
            IDLE: begin
                if (bus.start) begin
                    loadKey   = 1'b1;
                    stateNext = EXPAND;
                end
            end
            EXPAND: begin
                writeWord = 1'b1;
                if (idxReg == LastIdx) begin
                    lastWord  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // window[0] is w[idx-Nk], window[Nk-1] is w[idx-1]
    assign temp   = window[Nk-1];
    assign sboxIn = (subIdxReg == 3'd0) ? {temp[23:0], temp[31:24]} : temp;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gSbox
            assign sboxOut[8*gi +: 8] = SubTable[sboxIn[8*gi +: 8]];
        end
    endgenerate

    always_comb begin
        mixed = temp;
        if (subIdxReg == 3'd0)
            mixed = sboxOut ^ {rconReg, 24'h0};
        else if (Nk == 8 && subIdxReg == 3'd4)
            mixed = sboxOut;
    end
    assign newWord = window[0] ^ mixed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idxReg    <= 6'd0;
            subIdxReg <= 3'd0;
            rconReg   <= 8'h01;
            doneReg   <= 1'b0;
            readyReg  <= 1'b0;
        end else begin
            doneReg <= lastWord;
            if (loadKey) begin
                idxReg    <= NkIdx;
                subIdxReg <= 3'd0;
                rconReg   <= 8'h01;
                readyReg  <= 1'b0;
            end else if (writeWord) begin
                idxReg    <= idxReg + 6'd1;
                subIdxReg <= (subIdxReg == NkLast) ? 3'd0 : subIdxReg + 3'd1;
                if (subIdxReg == 3'd0)
                    rconReg <= {rconReg[6:0], 1'b0} ^ (rconReg[7] ? 8'h1b : 8'h00);
                if (lastWord)
                    readyReg <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < Nk; gi++) begin : gWindow
            always_ff @(posedge clk) begin
                if (loadKey)
                    window[gi] <= bus.keyIn[32*(Nk-gi)-1 -: 32];
                else if (writeWord) begin
                    if (gi == Nk - 1) window[gi] <= newWord;
                    else              window[gi] <= window[(gi+1) % Nk];
                end
            end
        end
    endgenerate

    assign rdOk = readyReg && (bus.rdRound <= NrIdx);

    // Word w[i] lives in lane i%4, row i/4, so a round key is one row across all lanes
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gLane
            logic [31:0] laneMem [0:Nr];
            logic [31:0] rdLaneReg;

            always_ff @(posedge clk) begin
                if (loadKey) begin
                    for (int j = 0; j < Nk; j++)
                        if (j % 4 == gi)
                            laneMem[4'(j/4)] <= bus.keyIn[32*(Nk-j)-1 -: 32];
                end else if (writeWord && idxReg[1:0] == 2'(gi)) begin
                    laneMem[idxReg[5:2]] <= newWord;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset)     rdLaneReg <= 32'h0;
                else if (rdOk) rdLaneReg <= laneMem[bus.rdRound];
                else           rdLaneReg <= 32'h0;
            end

            assign bus.rdKey[127-32*gi -: 32] = rdLaneReg;
        end
    endgenerate

    assign bus.busy  = (stateReg == EXPAND);
    assign bus.done  = doneReg;
    assign bus.ready = readyReg;
endmodule

// File: tb/tb_key_schedule_engine.sv
// Directed bench for key_schedule_engine: FIPS-197 schedules for Nk=4/6/8, latency,
// ignored start, restart on done, and asynchronous reset mid-expansion.
module tb_key_schedule_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    key_schedule_engine_if #(.Nk(4)) if4 ();
    key_schedule_engine_if #(.Nk(6)) if6 ();
    key_schedule_engine_if #(.Nk(8)) if8 ();

    key_schedule_engine #(.Nk(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
    key_schedule_engine #(.Nk(6)) dut6 (.clk(clk), .reset(reset), .bus(if6));
    key_schedule_engine #(.Nk(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));

    localparam logic [255:0] Key128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] Key192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] Key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        int           nk;
        logic [3:0]   rnd;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [13];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic getBusy(input int nk);
        case (nk)
            4: return if4.busy;
            6: return if6.busy;
            default: return if8.busy;
        endcase
    endfunction

    function automatic logic getDone(input int nk);
        case (nk)
            4: return if4.done;
            6: return if6.done;
            default: return if8.done;
        endcase
    endfunction

    function automatic logic getReady(input int nk);
        case (nk)
            4: return if4.ready;
            6: return if6.ready;
            default: return if8.ready;
        endcase
    endfunction

    function automatic logic [127:0] getKey(input int nk);
        case (nk)
            4: return if4.rdKey;
            6: return if6.rdKey;
            default: return if8.rdKey;
        endcase
    endfunction

    task automatic setStart(input int nk, input logic v);
        case (nk)
            4: if4.start = v;
            6: if6.start = v;
            default: if8.start = v;
        endcase
    endtask

    task automatic setKey(input int nk, input logic [255:0] key);
        case (nk)
            4: if4.keyIn = key[255:128];
            6: if6.keyIn = key[255:64];
            default: if8.keyIn = key;
        endcase
    endtask

    task automatic setRound(input int nk, input logic [3:0] r);
        case (nk)
            4: if4.rdRound = r;
            6: if6.rdRound = r;
            default: if8.rdRound = r;
        endcase
    endtask

    task automatic readRound(input int nk, input logic [3:0] r, input logic [127:0] exp);
        setRound(nk, r);
        @(negedge clk);
        $display("read nk=%0d round=%0d rdKey=%h", nk, r, getKey(nk));
        check($sformatf("rd_nk%0d_r%0d", nk, r), getKey(nk), exp);
    endtask

    // glitchKind 0: extra start pulse at cycle glitchAt; 1: reset at cycle glitchAt
    task automatic runExpand(input int nk, input logic [255:0] key, input int glitchAt,
                             input int glitchKind, output int lat, output int busyCnt);
        lat = 0;
        busyCnt = 0;
        setKey(nk, key);
        setStart(nk, 1'b1);
        @(negedge clk);
        setStart(nk, 1'b0);
        check($sformatf("ready_drop_nk%0d", nk), 128'(getReady(nk)), 128'd0);
        check($sformatf("busy_rise_nk%0d", nk), 128'(getBusy(nk)), 128'd1);
        while (!getDone(nk) && lat < 200) begin
            if (getBusy(nk)) busyCnt++;
            if (lat == glitchAt && glitchKind == 0) begin
                setKey(nk, ~key);
                setStart(nk, 1'b1);
            end else begin
                setStart(nk, 1'b0);
            end
            if (lat == glitchAt && glitchKind == 1) begin
                reset = 1'b1;
                #1;
                check("rst_busy", 128'(getBusy(nk)), 128'd0);
                check("rst_done", 128'(getDone(nk)), 128'd0);
                check("rst_ready", 128'(getReady(nk)), 128'd0);
                check("rst_rdkey", getKey(nk), 128'd0);
                $display("expand nk=%0d reset at cycle %0d", nk, lat);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (lat == 25)
                check($sformatf("busy_read_zero_nk%0d", nk), getKey(nk), 128'd0);
            @(negedge clk);
            lat++;
        end
        setStart(nk, 1'b0);
        $display("expand nk=%0d latency=%0d busyCycles=%0d", nk, lat, busyCnt);
    endtask

    initial begin
        int lat, bc;
        vecs[0]  = '{4, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1]  = '{4, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2]  = '{4, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3]  = '{4, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[4]  = '{4, 4'd11, 128'h0};
        vecs[5]  = '{6, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5};
        vecs[6]  = '{6, 4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5};
        vecs[7]  = '{6, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
        vecs[8]  = '{6, 4'd13, 128'h0};
        vecs[9]  = '{8, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4};
        vecs[10] = '{8, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde};
        vecs[11] = '{8, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};
        vecs[12] = '{8, 4'd15, 128'h0};

        foreach (vecs[i]) begin
            setStart(vecs[i].nk, 1'b0);
            setKey(vecs[i].nk, 256'h0);
            setRound(vecs[i].nk, 4'd0);
        end

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 128'(if4.busy), 128'd0);
        check("reset_done", 128'(if4.done), 128'd0);
        check("reset_ready", 128'(if4.ready), 128'd0);
        check("reset_rdkey", if4.rdKey, 128'd0);

        runExpand(4, Key128, -1, 0, lat, bc);
        check("lat_nk4", 128'(lat), 128'd40);
        check("busy_cycles_nk4", 128'(bc), 128'd40);
        @(negedge clk);
        check("done_pulse_nk4", 128'(if4.done), 128'd0);
        check("ready_held_nk4", 128'(if4.ready), 128'd1);

        runExpand(6, Key192, -1, 0, lat, bc);
        check("lat_nk6", 128'(lat), 128'd46);
        check("busy_cycles_nk6", 128'(bc), 128'd46);
        runExpand(8, Key256, -1, 0, lat, bc);
        check("lat_nk8", 128'(lat), 128'd52);
        check("busy_cycles_nk8", 128'(bc), 128'd52);

        foreach (vecs[i])
            readRound(vecs[i].nk, vecs[i].rnd, vecs[i].exp);

        // second start mid-expansion must not disturb the schedule
        setRound(4, 4'd1);
        runExpand(4, Key128, 10, 0, lat, bc);
        check("lat_ignored_start", 128'(lat), 128'd40);
        readRound(4, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        readRound(4, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        readRound(4, 4'd11, 128'h0);

        // restart on the done cycle with an all-zero key
        runExpand(4, Key128, -1, 0, lat, bc);
        runExpand(4, 256'h0, -1, 0, lat, bc);
        check("lat_zero_key", 128'(lat), 128'd40);
        readRound(4, 4'd1, 128'h62636363626363636263636362636363);
        readRound(4, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // reset mid-expansion, then a clean restart
        runExpand(4, Key128, 20, 1, lat, bc);
        check("post_reset_ready", 128'(if4.ready), 128'd0);
        check("post_reset_no_done", 128'(if4.done), 128'd0);
        runExpand(4, Key128, -1, 0, lat, bc);
        check("lat_after_reset", 128'(lat), 128'd40);
        readRound(4, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        readRound(4, 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
